// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU: opcodes, FSM state encoding,
// flag-vector bit positions and a small opcode helper.
package alu_pkg;

  localparam logic [2:0] OP_NAND = 3'b000;
  localparam logic [2:0] OP_SHR  = 3'b001;
  localparam logic [2:0] OP_SHL  = 3'b010;
  localparam logic [2:0] OP_ADD  = 3'b011;
  localparam logic [2:0] OP_SUB  = 3'b100;
  localparam logic [2:0] OP_CMP  = 3'b101;
  localparam logic [2:0] OP_MAX  = 3'b110;
  localparam logic [2:0] OP_PASS = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam int FL_CARRY = 0;
  localparam int FL_SIGN  = 1;
  localparam int FL_ZERO  = 2;
  localparam int FL_OVF   = 3;
  localparam int FL_EQ    = 4;
  localparam int FL_N     = 5;

  function automatic logic is_shift(input logic [2:0] o);
    return (o == OP_SHR) || (o == OP_SHL);
  endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational datapath of the ALU: single-cycle ops plus flag generation.
// For shift ops the already-shifted value arrives on sh; a is the original
// operand, used for the shift overflow flag.
// Optional macro ALU_ASR_EN: SHR is arithmetic, so its overflow is always 0.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] sh_i,
  input  logic             cin_i,
  output logic [WIDTH-1:0] res_o,
  output logic [FL_N-1:0]  flags_o
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;

  assign sum  = {1'b0, a_i} + {1'b0, b_i} + {{WIDTH{1'b0}}, cin_i};
  assign diff = {1'b0, a_i} - {1'b0, b_i};

  // Select the op result and derive carry/overflow/equal, then sign/zero
  always_comb begin
    res_o   = '0;
    flags_o = '0;
    case (op_i)
      OP_NAND: res_o = ~(a_i & b_i);
      OP_SHR: begin
        res_o = sh_i;
`ifdef ALU_ASR_EN
        flags_o[FL_OVF] = 1'b0;
`else
        flags_o[FL_OVF] = sh_i[WIDTH-1] ^ a_i[WIDTH-1];
`endif
      end
      OP_SHL: begin
        res_o           = sh_i;
        flags_o[FL_OVF] = sh_i[WIDTH-1] ^ a_i[WIDTH-1];
      end
      OP_ADD: begin
        res_o             = sum[WIDTH-1:0];
        flags_o[FL_CARRY] = sum[WIDTH];
        flags_o[FL_OVF]   = (a_i[WIDTH-1] == b_i[WIDTH-1]) &&
                            (sum[WIDTH-1] != a_i[WIDTH-1]);
      end
      OP_SUB: begin
        res_o             = diff[WIDTH-1:0];
        flags_o[FL_CARRY] = diff[WIDTH];
        flags_o[FL_OVF]   = (a_i[WIDTH-1] != b_i[WIDTH-1]) &&
                            (diff[WIDTH-1] != a_i[WIDTH-1]);
      end
      OP_CMP: begin
        res_o          = a_i;
        flags_o[FL_EQ] = (a_i == b_i);
      end
      OP_MAX:  res_o = (a_i < b_i) ? b_i : a_i;
      OP_PASS: res_o = a_i;
      default: res_o = a_i;
    endcase
    flags_o[FL_SIGN] = res_o[WIDTH-1];
    flags_o[FL_ZERO] = ~|res_o;
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready handshakes, registered result/flags,
// stored carry for chained ADD and an iterative one-bit-per-cycle shifter.
// Optional macro ALU_ASR_EN: SHR fills with the operand sign bit.
module alu_mc
  import alu_pkg::*;
#(
  parameter  int WIDTH = 16,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  input  logic [SHW-1:0]   shamt,
  input  logic             carry_in,
  input  logic             use_cf,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             sign,
  output logic             zero,
  output logic             overflow,
  output logic             equal
);

  state_t           state_q;
  logic [2:0]       op_q;
  logic [SHW-1:0]   cnt_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] sh_q;
  logic [WIDTH-1:0] sh_step;
  logic [WIDTH-1:0] result_q;
  logic [FL_N-1:0]  flags_q;
  logic             cf_q;
  logic             accept;

  logic [2:0]       core_op;
  logic [WIDTH-1:0] core_a;
  logic [WIDTH-1:0] core_b;
  logic [WIDTH-1:0] core_sh;
  logic             core_cin;
  logic [WIDTH-1:0] core_res;
  logic [FL_N-1:0]  core_fl;

  assign in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == ST_DONE);
  assign result    = result_q;
  assign carry     = flags_q[FL_CARRY];
  assign sign      = flags_q[FL_SIGN];
  assign zero      = flags_q[FL_ZERO];
  assign overflow  = flags_q[FL_OVF];
  assign equal     = flags_q[FL_EQ];

  // One-bit step of the iterative shifter in the direction of the held op
  always_comb begin
    sh_step = sh_q << 1;
    if (op_q == OP_SHR) begin
`ifdef ALU_ASR_EN
      sh_step = {sh_q[WIDTH-1], sh_q[WIDTH-1:1]};
`else
      sh_step = {1'b0, sh_q[WIDTH-1:1]};
`endif
    end
  end

  // Core sees live inputs at accept, held operands on the final shift step
  always_comb begin
    core_op  = op;
    core_a   = data1;
    core_b   = data2;
    core_sh  = data1;
    core_cin = use_cf ? cf_q : carry_in;
    if (state_q == ST_SHIFT) begin
      core_op  = op_q;
      core_a   = a_q;
      core_b   = '0;
      core_sh  = sh_step;
      core_cin = 1'b0;
    end
  end

  alu_core #(.WIDTH(WIDTH)) u_core (
    .op_i    (core_op),
    .a_i     (core_a),
    .b_i     (core_b),
    .sh_i    (core_sh),
    .cin_i   (core_cin),
    .res_o   (core_res),
    .flags_o (core_fl)
  );

  // Operand and shift registers; pure data, no reset needed
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q  <= data1;
      sh_q <= data1;
    end else if (state_q == ST_SHIFT) begin
      sh_q <= sh_step;
    end
  end

  // Control FSM with registered result, flags and stored carry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_NAND;
      cnt_q    <= '0;
      result_q <= '0;
      flags_q  <= '0;
      cf_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (accept) begin
            op_q <= op;
            if (is_shift(op) && (shamt != '0)) begin
              state_q <= ST_SHIFT;
              cnt_q   <= shamt;
            end else begin
              state_q  <= ST_DONE;
              result_q <= core_res;
              flags_q  <= core_fl;
              if ((op == OP_ADD) || (op == OP_SUB)) cf_q <= core_fl[FL_CARRY];
            end
          end else if ((state_q == ST_DONE) && out_ready) begin
            state_q <= ST_IDLE;
          end
        end
        ST_SHIFT: begin
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == SHW'(1)) begin
            state_q  <= ST_DONE;
            result_q <= core_res;
            flags_q  <= core_fl;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc: stimulus pushes expected responses from a
// behavioural model; a separate monitor pops and compares on output handshakes.
module tb_alu_mc;

  typedef struct {
    logic [15:0] res;
    logic [4:0]  fl;   // {equal, overflow, zero, sign, carry}
    int          acc;
    int          lat;
  } exp_t;

  logic        clk, rst_n, in_valid, in_ready, out_valid, out_ready;
  logic [2:0]  op;
  logic [15:0] data1, data2, result;
  logic [3:0]  shamt;
  logic        carry_in, use_cf, carry, sign, zero, overflow, equal;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   cyc = 0;
  logic mcf;
  logic rand_rdy;
  logic fresh;

  alu_mc #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .data1(data1), .data2(data2), .shamt(shamt),
    .carry_in(carry_in), .use_cf(use_cf), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .carry(carry), .sign(sign),
    .zero(zero), .overflow(overflow), .equal(equal)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic [2:0] o, input logic [15:0] a,
                                 input logic [15:0] b, input int s, input logic cin);
    exp_t e;
    int   r, sa, sb_;
    e.res = '0; e.fl = '0; e.acc = 0; e.lat = 0;
    sa  = int'($signed(a));
    sb_ = int'($signed(b));
    case (o)
      3'd0: e.res = ~(a & b);
      3'd1: begin
`ifdef ALU_ASR_EN
        e.res = 16'($signed(a) >>> s);
`else
        e.res = a >> s;
        e.fl[3] = (e.res[15] != a[15]);
`endif
      end
      3'd2: begin
        e.res = a << s;
        e.fl[3] = (e.res[15] != a[15]);
      end
      3'd3: begin
        r = int'(a) + int'(b) + int'(cin);
        e.res = r[15:0];
        e.fl[0] = (r > 65535);
        r = sa + sb_ + int'(cin);
        e.fl[3] = (r > 32767) || (r < -32768);
      end
      3'd4: begin
        r = int'(a) - int'(b);
        e.res = r[15:0];
        e.fl[0] = (a < b);
        r = sa - sb_;
        e.fl[3] = (r > 32767) || (r < -32768);
      end
      3'd5: begin
        e.res = a;
        e.fl[4] = (a == b);
      end
      3'd6: e.res = (a < b) ? b : a;
      default: e.res = a;
    endcase
    e.fl[1] = e.res[15];
    e.fl[2] = (e.res == 16'h0000);
    return e;
  endfunction

  // advance to just after the next rising edge, optionally randomising out_ready
  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic issue(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b,
                       input logic [3:0] s, input logic cin, input logic ucf,
                       output int waits);
    exp_t e;
    op = o; data1 = a; data2 = b; shamt = s; carry_in = cin; use_cf = ucf;
    in_valid = 1'b1;
    waits = 0;
    @(negedge clk);
    while (!in_ready && waits < 100) begin
      tick();
      @(negedge clk);
      waits++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_fail++;
      $display("FAIL accept_timeout: in_ready stuck 0, required 1 within 100 cycles");
      in_valid = 1'b0;
      return;
    end
    e = model(o, a, b, int'(s), ucf ? mcf : cin);
    e.acc = cyc;
    e.lat = ((o == 3'd1 || o == 3'd2) && s != 4'd0) ? int'(s) + 1 : 1;
    if (o == 3'd3 || o == 3'd4) mcf = e.fl[0];
    sb.push_back(e);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && sb.size() != 0; i++) tick();
    n_cmp++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d results outstanding, required 0", sb.size());
    end
  endtask

  // monitor: compare the head of the scoreboard whenever a result is presented
  initial begin
    fresh = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        sb.delete();
        fresh = 1'b1;
      end else if (out_valid) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL spurious_valid: out_valid=1 with result 0x%0h, none expected", result);
        end else begin
          if (fresh) begin
            chk("latency", cyc - sb[0].acc, sb[0].lat);
            fresh = 1'b0;
          end
          chk("result", int'(result), int'(sb[0].res));
          chk("flags", int'({equal, overflow, zero, sign, carry}), int'(sb[0].fl));
          if (out_ready) begin
            void'(sb.pop_front());
            fresh = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    int w;
    logic [15:0] a, b;
    logic [15:0] corner [5];
    corner[0] = 16'h0000; corner[1] = 16'hFFFF; corner[2] = 16'h7FFF;
    corner[3] = 16'h8000; corner[4] = 16'h0001;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; rand_rdy = 1'b0;
    op = '0; data1 = '0; data2 = '0; shamt = '0; carry_in = 1'b0; use_cf = 1'b0;
    mcf = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_result", int'(result), 0);
    chk("rst_flags", int'({equal, overflow, zero, sign, carry}), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // directed cases
    issue(3'd3, 16'h7FFF, 16'h0001, 4'd0, 1'b0, 1'b0, w);
    issue(3'd3, 16'hFFFF, 16'h0001, 4'd0, 1'b0, 1'b0, w);
    issue(3'd3, 16'h0000, 16'h0000, 4'd0, 1'b0, 1'b1, w);
    issue(3'd2, 16'h4001, 16'h0000, 4'd3, 1'b0, 1'b0, w);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("shift_in_ready", int'(in_ready), 0);
    end
    issue(3'd1, 16'h8000, 16'h0000, 4'd15, 1'b0, 1'b0, w);
    issue(3'd1, 16'h8000, 16'h0000, 4'd0, 1'b0, 1'b0, w);
    issue(3'd4, 16'h0000, 16'h0001, 4'd0, 1'b0, 1'b0, w);
    issue(3'd5, 16'h1234, 16'h1234, 4'd0, 1'b0, 1'b0, w);
    drain();

    // hold result for 5 cycles, then release together with a new request
    out_ready = 1'b0;
    issue(3'd6, 16'h00FF, 16'hFF00, 4'd0, 1'b0, 1'b0, w);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_in_ready", int'(in_ready), 0);
      tick();
    end
    out_ready = 1'b1;
    issue(3'd0, 16'hF0F0, 16'hFF00, 4'd0, 1'b0, 1'b0, w);
    chk("release_accept_waits", w, 0);
    drain();

    // randomised traffic with random backpressure
    rand_rdy = 1'b1;
    for (int n = 0; n < 300; n++) begin
      a = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : 16'($urandom);
      b = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : 16'($urandom);
      if ($urandom_range(0, 7) == 0) b = a;
      issue(3'($urandom_range(0, 7)), a, b, 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), w);
      repeat ($urandom_range(0, 2)) tick();
    end
    rand_rdy = 1'b0;
    out_ready = 1'b1;
    drain();

    // reset in the middle of a shift
    issue(3'd3, 16'hFFFF, 16'h0001, 4'd0, 1'b0, 1'b0, w);
    issue(3'd1, 16'hA5A5, 16'h0000, 4'd10, 1'b0, 1'b0, w);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", int'(out_valid), 0);
    chk("arst_result", int'(result), 0);
    chk("arst_flags", int'({equal, overflow, zero, sign, carry}), 0);
    chk("arst_in_ready", int'(in_ready), 1);
    mcf = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    issue(3'd3, 16'h0000, 16'h0000, 4'd0, 1'b1, 1'b1, w);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
